// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: two-flop synchroniser plus per-bit tick-based debouncer with edge pulses
module sw_debounce_sync #(
    parameter int              WIDTH        = 18,
    parameter int              TICK_DIV     = 50000,
    parameter int              STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change,
    output logic             tick
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] sync1, sync2, differ, expire;
    logic [CW-1:0]    cnt [WIDTH];

    // bring the asynchronous pins into clk before anything looks at them
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // shared prescaler; tick is high the cycle after the counter reaches its top
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= presc == PW'(TICK_DIV - 1);
            presc <= presc == PW'(TICK_DIV - 1) ? '0 : presc + PW'(1);
        end
    end

    // a bit commits when it has differed across its final required tick
    always_comb begin
        differ = sync2 ^ sw_out;
        expire = '0;
        for (int i = 0; i < WIDTH; i++)
            expire[i] = differ[i] && tick && cnt[i] == CW'(STABLE_TICKS - 1);
    end

    // per-bit stability counters; any agreement with sw_out aborts the count
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++)
            if (reset)
                cnt[i] <= '0;
            else
                cnt[i] <= (!differ[i] || expire[i]) ? '0 : tick ? cnt[i] + CW'(1) : cnt[i];
    end

    // debounced state and its single-cycle edge pulses, all updated together
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_out     <= RESET_VALUE;
            sw_rise    <= '0;
            sw_fall    <= '0;
            any_change <= 1'b0;
        end else begin
            sw_out     <= (sw_out & ~expire) | (sync2 & expire);
            sw_rise    <= expire & sync2;
            sw_fall    <= expire & ~sync2;
            any_change <= |expire;
        end
    end
endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync: directed and random checks of the debouncer against a tick-counting reference
module tb_sw_debounce_sync;
    localparam int W  = 18;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '1;
    logic [W-1:0] sw_out, sw_rise, sw_fall;
    logic         any_change, tick;
    logic [W-1:0] raw1 = '0;
    logic [W-1:0] out1, rise1, fall1;
    logic         any1, tick1;

    int checks = 0;
    int failures = 0;

    sw_debounce_sync #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VALUE('0)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_out(sw_out),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .any_change(any_change), .tick(tick)
    );

    sw_debounce_sync #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VALUE('0)) dut1 (
        .clk(clk), .reset(reset), .sw_raw(raw1), .sw_out(out1),
        .sw_rise(rise1), .sw_fall(fall1), .any_change(any1), .tick(tick1)
    );

    always #5 clk = ~clk;

    // reference: pins seen two edges late, tick every TD-th edge since reset,
    // a bit commits once it has differed through ST tick cycles in a row
    logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic         m_any, m_tick;
    int           k;
    int           run [W];

    task automatic model_step();
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            m_any = 1'b0; m_tick = 1'b0; k = 0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] == m_out[i]) run[i] = 0;
                else if (m_tick) begin
                    run[i] = run[i] + 1;
                    if (run[i] == ST) begin
                        run[i] = 0;
                        m_out[i] = m_s2[i];
                        m_rise[i] = m_s2[i];
                        m_fall[i] = !m_s2[i];
                    end
                end
            end
            m_any = |(m_rise | m_fall);
            m_s2 = m_s1;
            m_s1 = sw_raw;
            k = k + 1;
            m_tick = (k % TD) == 0;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got out=%h rise=%h fall=%h any=%b tick=%b want all 0",
                         n, sw_out, sw_rise, sw_fall, any_change, tick);
            end
        end
        reset = 1'b0;
        sw_raw = '0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            checks++;
            if (tick !== ((j % TD) == 0)) begin
                failures++;
                $display("FAIL reset_tick_phase cyc=%0d got tick=%b want %b", j, tick, (j % TD) == 0);
            end
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL reset_model got out=%h rise=%h fall=%h any=%b tick=%b want out=%h rise=%h fall=%h any=%b tick=%b",
                         sw_out, sw_rise, sw_fall, any_change, tick, m_out, m_rise, m_fall, m_any, m_tick);
            end
        end
    endtask

    task automatic test_clean_step();
        int n;
        sw_raw[0] = 1'b1;
        n = 0;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL step_model got out=%h rise=%h fall=%h any=%b want out=%h rise=%h fall=%h any=%b",
                         sw_out, sw_rise, sw_fall, any_change, m_out, m_rise, m_fall, m_any);
            end
            if (sw_out[0]) n = c;
        end
        checks++;
        if (n < 2 + (ST - 1) * TD + 1 || n > 2 + ST * TD + 1) begin
            failures++;
            $display("FAIL step_latency got %0d cycles want %0d..%0d", n, 2 + (ST - 1) * TD + 1, 2 + ST * TD + 1);
        end
        checks++;
        if ({sw_rise, sw_fall, any_change} !== {18'h00001, 18'h0, 1'b1}) begin
            failures++;
            $display("FAIL step_pulse got rise=%h fall=%h any=%b want rise=00001 fall=0 any=1", sw_rise, sw_fall, any_change);
        end
        @(negedge clk);
        checks++;
        if ({sw_rise, any_change} !== '0 || sw_out !== 18'h00001) begin
            failures++;
            $display("FAIL step_pulse_end got out=%h rise=%h any=%b want out=00001 rise=0 any=0", sw_out, sw_rise, any_change);
        end
    endtask

    task automatic test_bounce();
        int n;
        for (int c = 0; c < 60; c++) begin
            sw_raw[5] = (c % 7) < 5;
            @(negedge clk);
            checks++;
            if (sw_out[5] !== 1'b0 || sw_rise[5] !== 1'b0 || sw_fall[5] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_hold cyc=%0d got out5=%b rise5=%b fall5=%b want 0 0 0", c, sw_out[5], sw_rise[5], sw_fall[5]);
            end
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL bounce_model got out=%h any=%b want out=%h any=%b", sw_out, any_change, m_out, m_any);
            end
        end
        sw_raw[5] = 1'b1;
        n = 0;
        for (int c = 1; c <= 30 && n == 0; c++) begin
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL bounce_settle_model got out=%h any=%b want out=%h any=%b", sw_out, any_change, m_out, m_any);
            end
            if (sw_out[5]) n = c;
        end
        checks++;
        if (n == 0 || n > 2 + ST * TD + 1) begin
            failures++;
            $display("FAIL bounce_settle got %0d cycles (0 = never) want 1..%0d", n, 2 + ST * TD + 1);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        bit seen;
        sw_raw = 18'h20000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL simul_setup_model got out=%h any=%b want out=%h any=%b", sw_out, any_change, m_out, m_any);
            end
        end
        checks++;
        if (sw_out !== 18'h20000) begin
            failures++;
            $display("FAIL simul_setup got out=%h want 20000", sw_out);
        end
        sw_raw = 18'h00008;
        pulses = 0;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL simul_model got out=%h rise=%h fall=%h any=%b want out=%h rise=%h fall=%h any=%b",
                         sw_out, sw_rise, sw_fall, any_change, m_out, m_rise, m_fall, m_any);
            end
            if (any_change) pulses++;
            if (!seen && sw_out !== 18'h20000) begin
                seen = 1'b1;
                checks++;
                if ({sw_out, sw_rise, sw_fall} !== {18'h00008, 18'h00008, 18'h20000}) begin
                    failures++;
                    $display("FAIL simul_update got out=%h rise=%h fall=%h want out=00008 rise=00008 fall=20000",
                             sw_out, sw_rise, sw_fall);
                end
            end
        end
        checks++;
        if (pulses != 1 || sw_out !== 18'h00008) begin
            failures++;
            $display("FAIL simul_single_pulse got pulses=%0d out=%h want pulses=1 out=00008", pulses, sw_out);
        end
    endtask

    task automatic test_reset_mid();
        int ticks;
        int n;
        sw_raw = 18'h0000C;
        ticks = 0;
        for (int c = 1; c <= 20 && ticks < 2; c++) begin
            @(negedge clk);
            if (c >= 2 && tick) ticks++;
        end
        checks++;
        if (sw_out[2] !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_precount got out2=%b want 0", sw_out[2]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({sw_out, sw_rise, sw_fall, any_change, tick} !== '0) begin
            failures++;
            $display("FAIL resetmid_cleared got out=%h rise=%h fall=%h any=%b tick=%b want all 0",
                     sw_out, sw_rise, sw_fall, any_change, tick);
        end
        ticks = 0;
        n = 0;
        for (int c = 1; c <= 30 && n == 0; c++) begin
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL resetmid_model got out=%h any=%b tick=%b want out=%h any=%b tick=%b",
                         sw_out, any_change, tick, m_out, m_any, m_tick);
            end
            if (sw_out[2]) n = c;
            else if (tick) ticks++;
        end
        checks++;
        if (n == 0 || ticks != ST) begin
            failures++;
            $display("FAIL resetmid_restart got ticks_before=%0d cyc=%0d (0 = never) want ticks_before=%0d", ticks, n, ST);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) sw_raw = W'($urandom);
            else if ($urandom_range(0, 7) == 0) sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            @(negedge clk);
            checks++;
            if ({sw_out, sw_rise, sw_fall, any_change, tick} !== {m_out, m_rise, m_fall, m_any, m_tick}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got out=%h rise=%h fall=%h any=%b tick=%b want out=%h rise=%h fall=%h any=%b tick=%b",
                         c, sw_out, sw_rise, sw_fall, any_change, tick, m_out, m_rise, m_fall, m_any, m_tick);
            end
        end
    endtask

    task automatic test_degenerate();
        logic [W-1:0] v [64];
        for (int m = 0; m < 4; m++) v[m] = '0;
        for (int m = 4; m < 64; m++) begin
            @(negedge clk);
            checks++;
            if ({out1, rise1, fall1, any1, tick1} !==
                {v[m-3], v[m-3] & ~v[m-4], ~v[m-3] & v[m-4], v[m-3] != v[m-4], 1'b1}) begin
                failures++;
                $display("FAIL degenerate cyc=%0d got out=%h rise=%h fall=%h any=%b tick=%b want out=%h prev=%h tick=1",
                         m, out1, rise1, fall1, any1, tick1, v[m-3], v[m-4]);
            end
            v[m] = $urandom_range(0, 1) ? W'($urandom) : v[m-1];
            raw1 = v[m];
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_degenerate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
